best_match_tracker: RTL and testbench
=====================================

// Module: best_match_tracker
// PURPOSE
//  Sits directly downstream of the SAD core's final minimum stage. Consumes one
//  {index, SAD} candidate per cycle and keeps a running global minimum across a
//  full search pass. The pass closes on the TriggerBoss-marked candidate.
//  Presents the winning index/value with a ready/ack handshake to the host/display logic.
// PARAMETERS
//  IDX_W      16   width of candidate index (matches core output)
//  SAD_W      14   width of SAD value (matches core output)
//  CNT_W      16   width of candidate counter
//  FRAME_W    64   frame row pitch in pixels, used only with SAD_COORD_OUT_EN
// PORTS
//  clk          in   1      rising-edge clock
//  Reset        in   1      synchronous, active-high reset
//  Start        in   1      pulse: clear tracker, begin a new search pass
//  InValid      in   1      InIndex/InValue/InTriggerBoss valid this cycle
//  InIndex      in   IDX_W  candidate index from core
//  InValue      in   SAD_W  candidate SAD from core
//  InTriggerBoss in  1      marks last candidate of the pass
//  ResultAck    in   1      consumer accepts result (DONE only)
//  Busy         out  1      1 in SEARCH
//  ResultValid  out  1      1 in DONE; result outputs stable while high
//  BestIndex    out  IDX_W  index of minimum SAD
//  BestValue    out  SAD_W  minimum SAD
//  CandCount    out  CNT_W  candidates accepted this pass
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, Busy=0, ResultValid=0, BestIndex=0,
//    BestValue={SAD_W{1'b1}}, CandCount=0, first-flag=1. Reset overrides all
//    other inputs, including mid-pass.
//  - FSM states: IDLE, SEARCH, DONE. All outputs are registered.
//  - Start (any state, highest priority after Reset) performs four actions:
//    clears Best*/CandCount/first-flag as at reset; sets next state to SEARCH;
//    ignores any InValid in the same cycle; in DONE, Start wins over a
//    simultaneous ResultAck.
//  - IDLE: InValid ignored. State holds until Start.
//  - SEARCH, InValid=1: CandCount += 1, saturating at all-ones.
//  - SEARCH, first candidate of the pass: always loads Best*.
//  - SEARCH, later candidates: load when InValue < BestValue (strict). Ties
//    keep the earlier index.
//  - SEARCH, InValid=1 && InTriggerBoss=1: candidate is compared as above, then
//    next state is DONE. ResultValid=1 on the following cycle, with Best*
//    already including that candidate (latency 1 clock from final candidate).
//  - SEARCH, InValid=0: no change. InTriggerBoss without InValid is ignored.
//  - DONE: Best*/CandCount frozen. Input candidates are ignored.
//  - DONE, ResultAck=1: next state IDLE, ResultValid=0 next cycle. Best* is held
//    until the next Start.
//  - ResultAck outside DONE is ignored.
//  - Widths: unsigned compare. No arithmetic on SAD; index passes through unmodified.
// CONFIGURATION
//  SAD_COORD_OUT_EN defined: adds registered outputs BestRow and BestCol, each
//    IDX_W wide. BestRow = BestIndex / FRAME_W and BestCol = BestIndex % FRAME_W.
//    FRAME_W must be a power of two (shift/mask). Both update in the same cycle
//    as BestIndex and reset to 0.
//  SAD_COORD_OUT_EN undefined: ports and logic absent. Core behaviour identical.
// TESTING
//  T1 reset: assert Reset 2 clks during SEARCH
//     -> IDLE, ResultValid=0, BestValue=16383, BestIndex=0, CandCount=0.
//  T2 basic pass: Start; candidates (idx,val,tb) = (0,500,0) (1,120,0)
//     (2,300,0) (3,90,1) -> next clk ResultValid=1, BestIndex=3,
//     BestValue=90, CandCount=4.
//  T3 tie/gaps: Start; (10,50,0), InValid=0 x3 cycles, (11,50,0), (12,60,1)
//     -> BestIndex=10, BestValue=50, CandCount=3.
//  T4 max value first: Start; (7,16383,1) -> BestIndex=7, BestValue=16383,
//     CandCount=1.
//  T5 handshake: in DONE hold Ack=0 for 5 clks while driving (99,0,1)
//     -> outputs unchanged. Ack=1 -> IDLE next clk.
//     Start+Ack same cycle -> SEARCH, cleared.
//  T6 macro on, FRAME_W=64: pass ending with best index 130
//     -> BestRow=2, BestCol=2, same cycle as ResultValid.

Source files
------------

// File: rtl/best_match_tracker.sv
// best_match_tracker: running global-minimum tracker for the SAD search core.
// Consumes one {index, SAD} candidate per cycle, keeps the smallest SAD seen in
// the current pass (earliest index wins ties), closes the pass on the
// TriggerBoss-marked candidate and holds the winner under a ready/ack handshake.
// Optional feature macro: SAD_COORD_OUT_EN adds BestRow/BestCol outputs derived
// from BestIndex with a power-of-two FRAME_W row pitch.
module best_match_tracker #(
  parameter int IDX_W   = 16,
  parameter int SAD_W   = 14,
  parameter int CNT_W   = 16,
  parameter int FRAME_W = 64
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             InValid,
  input  logic [IDX_W-1:0] InIndex,
  input  logic [SAD_W-1:0] InValue,
  input  logic             InTriggerBoss,
  input  logic             ResultAck,
  output logic             Busy,
  output logic             ResultValid,
  output logic [IDX_W-1:0] BestIndex,
  output logic [SAD_W-1:0] BestValue,
`ifdef SAD_COORD_OUT_EN
  output logic [IDX_W-1:0] BestRow,
  output logic [IDX_W-1:0] BestCol,
`endif
  output logic [CNT_W-1:0] CandCount
);

  // Row pitch must be a power of two so row/col reduce to shift and mask.
  if (FRAME_W <= 0 || (FRAME_W & (FRAME_W - 1)) != 0) begin : g_bad_frame_w
    $error("best_match_tracker: FRAME_W must be a power of two");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  logic   first;
  logic   take;

  // Candidate counter stops at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

`ifdef SAD_COORD_OUT_EN
  localparam int ROW_SH = $clog2(FRAME_W);

  function automatic logic [IDX_W-1:0] row_of(input logic [IDX_W-1:0] idx);
    return idx >> ROW_SH;
  endfunction

  function automatic logic [IDX_W-1:0] col_of(input logic [IDX_W-1:0] idx);
    return idx & IDX_W'(FRAME_W - 1);
  endfunction
`endif

  // A candidate replaces the best when it opens the pass or is strictly smaller.
  always_comb begin
    take = first || (InValue < BestValue);
  end

  // Control FSM with all outputs registered; Reset, then Start, take priority.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state       <= IDLE;
      Busy        <= 1'b0;
      ResultValid <= 1'b0;
      BestIndex   <= '0;
      BestValue   <= '1;
      CandCount   <= '0;
      first       <= 1'b1;
`ifdef SAD_COORD_OUT_EN
      BestRow     <= '0;
      BestCol     <= '0;
`endif
    end else if (Start) begin
      state       <= SEARCH;
      Busy        <= 1'b1;
      ResultValid <= 1'b0;
      BestIndex   <= '0;
      BestValue   <= '1;
      CandCount   <= '0;
      first       <= 1'b1;
`ifdef SAD_COORD_OUT_EN
      BestRow     <= '0;
      BestCol     <= '0;
`endif
    end else begin
      case (state)
        SEARCH: begin
          if (InValid) begin
            CandCount <= sat_inc(CandCount);
            first     <= 1'b0;
            if (take) begin
              BestIndex <= InIndex;
              BestValue <= InValue;
`ifdef SAD_COORD_OUT_EN
              BestRow   <= row_of(InIndex);
              BestCol   <= col_of(InIndex);
`endif
            end
            if (InTriggerBoss) begin
              state       <= DONE;
              Busy        <= 1'b0;
              ResultValid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ResultAck) begin
            state       <= IDLE;
            ResultValid <= 1'b0;
          end
        end
        default: begin
          // IDLE: wait for Start; candidates and acks are ignored.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_best_match_tracker.sv
// tb_best_match_tracker: scoreboard bench for best_match_tracker.
// The driver records accepted candidates per pass and, when the pass closes,
// pushes the reference winner (list minimum, earliest index on ties) into a
// queue; an independent monitor compares every cycle ResultValid is high.
module tb_best_match_tracker;

  localparam int IDX_W   = 16;
  localparam int SAD_W   = 14;
  localparam int CNT_W   = 16;
  localparam int FRAME_W = 64;
  localparam longint SAD_MAX = (64'd1 << SAD_W) - 1;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             Reset, Start, InValid, InTriggerBoss, ResultAck;
  logic [IDX_W-1:0] InIndex;
  logic [SAD_W-1:0] InValue;
  logic             Busy, ResultValid;
  logic [IDX_W-1:0] BestIndex;
  logic [SAD_W-1:0] BestValue;
  logic [CNT_W-1:0] CandCount;
`ifdef SAD_COORD_OUT_EN
  logic [IDX_W-1:0] BestRow, BestCol;
`endif

  best_match_tracker #(
    .IDX_W(IDX_W), .SAD_W(SAD_W), .CNT_W(CNT_W), .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk),
    .Reset(Reset),
    .Start(Start),
    .InValid(InValid),
    .InIndex(InIndex),
    .InValue(InValue),
    .InTriggerBoss(InTriggerBoss),
    .ResultAck(ResultAck),
    .Busy(Busy),
    .ResultValid(ResultValid),
    .BestIndex(BestIndex),
    .BestValue(BestValue),
`ifdef SAD_COORD_OUT_EN
    .BestRow(BestRow),
    .BestCol(BestCol),
`endif
    .CandCount(CandCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint idx;
    longint val;
    longint cnt;
    int     due;
  } exp_t;

  exp_t   exp_q[$];
  longint cand_idx[$];
  longint cand_val[$];
  bit     m_search = 1'b0;
  int     cyc = 0;
  int     tests = 0;
  int     fails = 0;
  bit     prev_rv = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference winner of the pass: scan the accepted list for its minimum.
  function automatic exp_t model_result();
    exp_t e;
    e.idx = cand_idx[0];
    e.val = cand_val[0];
    for (int i = 1; i < cand_val.size(); i++) begin
      if (cand_val[i] < e.val) begin
        e.val = cand_val[i];
        e.idx = cand_idx[i];
      end
    end
    e.cnt = (cand_val.size() > CNT_MAX) ? CNT_MAX : longint'(cand_val.size());
    e.due = 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass();
    Start = 1'b1;
    m_search = 1'b1;
    cand_idx.delete();
    cand_val.delete();
    step();
    Start = 1'b0;
  endtask

  task automatic cand(input bit v, input longint idx, input longint val, input bit trig);
    exp_t e;
    InValid = v;
    InIndex = IDX_W'(idx);
    InValue = SAD_W'(val);
    InTriggerBoss = trig;
    if (v && m_search) begin
      cand_idx.push_back(idx);
      cand_val.push_back(val);
      if (trig) begin
        e = model_result();
        e.due = cyc + 1;
        exp_q.push_back(e);
        m_search = 1'b0;
      end
    end
    step();
    InValid = 1'b0;
    InTriggerBoss = 1'b0;
  endtask

  task automatic ack();
    ResultAck = 1'b1;
    step();
    ResultAck = 1'b0;
  endtask

  // Monitor: compare the presented result against the scoreboard head.
  always @(negedge clk) begin
    if (ResultValid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got ResultValid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        if (!prev_rv) check("result_latency", 64'(cyc), 64'(exp_q[0].due));
        check("best_index", 64'(BestIndex), 64'(exp_q[0].idx));
        check("best_value", 64'(BestValue), 64'(exp_q[0].val));
        check("cand_count", 64'(CandCount), 64'(exp_q[0].cnt));
        check("busy_in_done", 64'(Busy), 64'd0);
`ifdef SAD_COORD_OUT_EN
        check("best_row", 64'(BestRow), 64'(exp_q[0].idx / FRAME_W));
        check("best_col", 64'(BestCol), 64'(exp_q[0].idx % FRAME_W));
`endif
      end
    end else if (prev_rv && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
    end
    prev_rv = ResultValid;
  end

  initial begin
    int n, gap;
    longint v;
    Reset = 1'b1; Start = 1'b0; InValid = 1'b0; InTriggerBoss = 1'b0;
    ResultAck = 1'b0; InIndex = '0; InValue = '0;
    step();
    step();
    Reset = 1'b0;
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_rv", 64'(ResultValid), 64'd0);
    check("rst_idx", 64'(BestIndex), 64'd0);
    check("rst_val", 64'(BestValue), 64'(SAD_MAX));
    check("rst_cnt", 64'(CandCount), 64'd0);

    // IDLE ignores candidates and acks
    ResultAck = 1'b1;
    cand(1'b1, 5, 3, 1'b1);
    ResultAck = 1'b0;
    check("idle_cnt", 64'(CandCount), 64'd0);
    check("idle_val", 64'(BestValue), 64'(SAD_MAX));
    check("idle_busy", 64'(Busy), 64'd0);

    // basic pass
    start_pass();
    check("start_busy", 64'(Busy), 64'd1);
    cand(1'b1, 0, 500, 1'b0);
    cand(1'b1, 1, 120, 1'b0);
    cand(1'b1, 2, 300, 1'b0);
    cand(1'b1, 3, 90, 1'b1);
    check("basic_rv", 64'(ResultValid), 64'd1);
    ack();
    check("ack_rv", 64'(ResultValid), 64'd0);
    check("ack_busy", 64'(Busy), 64'd0);
    check("ack_hold_idx", 64'(BestIndex), 64'd3);
    check("ack_hold_val", 64'(BestValue), 64'd90);

    // tie with gaps; trigger without valid is ignored
    start_pass();
    cand(1'b1, 10, 50, 1'b0);
    cand(1'b0, 77, 1, 1'b1);
    cand(1'b0, 0, 0, 1'b0);
    cand(1'b0, 0, 0, 1'b0);
    check("gap_busy", 64'(Busy), 64'd1);
    cand(1'b1, 11, 50, 1'b0);
    cand(1'b1, 12, 60, 1'b1);
    check("tie_rv", 64'(ResultValid), 64'd1);
    ack();

    // maximum value as the only candidate
    start_pass();
    cand(1'b1, 7, SAD_MAX, 1'b1);
    check("max_rv", 64'(ResultValid), 64'd1);
    ack();

    // reset mid-pass
    start_pass();
    cand(1'b1, 4, 20, 1'b0);
    cand(1'b1, 5, 10, 1'b0);
    Reset = 1'b1;
    m_search = 1'b0;
    step();
    step();
    Reset = 1'b0;
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_rv", 64'(ResultValid), 64'd0);
    check("midrst_val", 64'(BestValue), 64'(SAD_MAX));
    check("midrst_idx", 64'(BestIndex), 64'd0);
    check("midrst_cnt", 64'(CandCount), 64'd0);

    // DONE holds while candidates keep arriving without ack
    start_pass();
    cand(1'b1, 40, 33, 1'b0);
    cand(1'b1, 41, 8, 1'b1);
    for (int i = 0; i < 5; i++) cand(1'b1, 99, 0, 1'b1);
    check("hold_rv", 64'(ResultValid), 64'd1);
    check("hold_cnt", 64'(CandCount), 64'd2);
    ack();
    check("hold_ack_rv", 64'(ResultValid), 64'd0);
    check("hold_ack_val", 64'(BestValue), 64'd8);

    // Start and Ack together in DONE: Start wins
    start_pass();
    cand(1'b1, 300, 9, 1'b1);
    ResultAck = 1'b1;
    start_pass();
    ResultAck = 1'b0;
    check("startack_busy", 64'(Busy), 64'd1);
    check("startack_rv", 64'(ResultValid), 64'd0);
    check("startack_cnt", 64'(CandCount), 64'd0);
    check("startack_val", 64'(BestValue), 64'(SAD_MAX));
    check("startack_idx", 64'(BestIndex), 64'd0);

    // pass whose winner is index 130 (row 2, col 2 with a 64-pixel pitch)
    cand(1'b1, 200, 900, 1'b0);
    cand(1'b1, 130, 5, 1'b0);
    cand(1'b1, 131, 5, 1'b1);
    ack();

    // randomized passes
    for (int p = 0; p < 40; p++) begin
      start_pass();
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++)
          cand(1'b0, $urandom_range(0, 65535), $urandom_range(0, 63), $urandom_range(0, 1));
        v = ($urandom_range(0, 9) == 0) ? SAD_MAX : longint'($urandom_range(0, 63));
        cand(1'b1, $urandom_range(0, 65535), v, k == n - 1);
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        cand($urandom_range(0, 1), $urandom_range(0, 65535), $urandom_range(0, 63), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        ResultAck = 1'b1;
        start_pass();
        ResultAck = 1'b0;
        m_search = 1'b0;
        cand_idx.delete();
        cand_val.delete();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
      end else begin
        ack();
      end
    end

    step();
    step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
